// File: rtl/pipeline_pkg.sv
// Shared defaults and pointer-width helpers for the pipeline blocks.
package pipeline_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH      = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/pipeline_buf_ptr.sv
// Wrapping pointer counter with increment and synchronous clear.
module pipeline_buf_ptr
  import pipeline_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipeline_elastic_buf.sv
// First-word fall-through elastic buffer with flush, occupancy count and almost_full.
module pipeline_elastic_buf
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned AF_THRESH  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;

  // Handshake qualifiers depend only on count_q, so out_ready never reaches in_ready.
  assign in_ready    = (count_q < DEPTH_C);
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign out_data    = mem_q[rd_ptr];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  pipeline_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  pipeline_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pipeline_elastic_buf.sv
// Directed and scoreboarded checks for pipeline_elastic_buf (32 bits, 4 deep, AF at 3).
module tb_pipeline_elastic_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        almost_full;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    int unsigned cnt;
    logic        ov;
    logic        ir;
    logic        af;
    logic [31:0] od;
  } vec_t;

  vec_t vq[$];

  pipeline_elastic_buf #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .AF_THRESH  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                     input int unsigned cnt, input logic ov, input logic ir, input logic af,
                     input logic [31:0] od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.af = af; v.od = od;
    vq.push_back(v);
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  int unsigned cnt_m;
  logic [31:0] sb[$];
  int unsigned pops;
  int unsigned cycles;
  logic        iv_r, or_r, push_m, pop_m, prev_stall;
  logic [31:0] d_r, prev_od;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Vectors: {flush, in_valid, in_data, out_ready} -> state after the edge
    add(0, 1, 32'hA0, 0, 1, 1, 1, 0, 32'hA0);
    add(0, 1, 32'hA1, 0, 2, 1, 1, 0, 32'hA0);
    add(0, 1, 32'hA2, 0, 3, 1, 1, 1, 32'hA0);
    add(0, 1, 32'hA3, 0, 4, 1, 0, 1, 32'hA0);
    add(0, 1, 32'hB0, 1, 3, 1, 1, 1, 32'hA1);
    add(0, 0, 32'h00, 1, 2, 1, 1, 0, 32'hA2);
    add(0, 0, 32'h00, 1, 1, 1, 1, 0, 32'hA3);
    add(0, 1, 32'hE0, 1, 1, 1, 1, 0, 32'hE0);
    add(0, 0, 32'h00, 0, 1, 1, 1, 0, 32'hE0);
    add(0, 1, 32'hE1, 0, 2, 1, 1, 0, 32'hE0);
    add(0, 1, 32'hE2, 0, 3, 1, 1, 1, 32'hE0);
    add(1, 1, 32'hC0, 1, 0, 0, 1, 0, 32'h00);
    add(0, 0, 32'h00, 0, 0, 0, 1, 0, 32'h00);
    add(0, 1, 32'hF0, 0, 1, 1, 1, 0, 32'hF0);
    add(0, 0, 32'h00, 1, 0, 0, 1, 0, 32'h00);

    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].fl, vq[i].iv, vq[i].d, vq[i].ordy);
      chk($sformatf("vec%0d_count", i), 32'(count), vq[i].cnt);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vq[i].ir));
      chk($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'(vq[i].af));
      if (vq[i].ov) chk($sformatf("vec%0d_out_data", i), out_data, vq[i].od);
    end

    // Streaming: one beat per cycle, count held at 1, pointers wrap five times
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 32'(k), 1);
      chk($sformatf("stream%0d_count", k), 32'(count), 32'd1);
      chk($sformatf("stream%0d_out_data", k), out_data, 32'(k));
    end
    step(0, 0, 32'h0, 1);
    chk("stream_drain_count", 32'(count), 32'd0);

    // Random backpressure against a queue scoreboard
    cnt_m = 0; pops = 0; cycles = 0; prev_stall = 1'b0; prev_od = '0;
    while (pops < 1000 && cycles < 20000) begin
      chk("bp_count", 32'(count), cnt_m);
      chk("bp_out_valid", 32'(out_valid), 32'(cnt_m != 0));
      chk("bp_in_ready", 32'(in_ready), 32'(cnt_m < 4));
      chk("bp_almost_full", 32'(almost_full), 32'(cnt_m >= 3));
      if (cnt_m != 0) chk("bp_out_data", out_data, sb[0]);
      if (prev_stall) chk("bp_stall_stable", out_data, prev_od);
      iv_r = 1'($urandom_range(0, 1));
      or_r = ($urandom_range(0, 9) < 3);
      d_r  = $urandom;
      push_m = iv_r && (cnt_m < 4);
      pop_m  = or_r && (cnt_m != 0);
      prev_stall = (cnt_m != 0) && !or_r;
      prev_od = out_data;
      if (pop_m) begin
        void'(sb.pop_front());
        pops++;
      end
      if (push_m) sb.push_back(d_r);
      cnt_m = cnt_m + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      step(0, iv_r, d_r, or_r);
      cycles++;
    end
    chk("bp_pop_budget", 32'(pops >= 1000), 32'd1);

    // Reset mid-stream with two entries stored
    step(1, 0, 32'h0, 0);
    step(0, 1, 32'h11, 0);
    step(0, 1, 32'h22, 0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 32'hD0, 0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_out_data", out_data, 32'hD0);
    step(0, 0, 32'h0, 1);
    chk("post_rst_drain", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic_buf.md
PIPELINE_ELASTIC_BUF -- requirements
Module: pipeline_elastic_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, at least 1.
REQ-002 Parameter DEPTH, default 4: number of storage entries, a power of two, at least 2.
REQ-003 Parameter AF_THRESH, default DEPTH-1: occupancy at which almost_full asserts, from 1 to DEPTH.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous discard of all stored entries.
REQ-007 in_valid  in  1  upstream has a beat.
REQ-008 in_ready  out  1  buffer can accept a beat.
REQ-009 in_data  in  DATA_WIDTH  upstream payload.
REQ-010 out_valid  out  1  head entry available.
REQ-011 out_ready  in  1  downstream accepts the head entry.
REQ-012 out_data  out  DATA_WIDTH  head entry payload.
REQ-013 count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-014 almost_full  out  1  high when count >= AF_THRESH.

Function
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-016 in_ready SHALL be (count < DEPTH), decoded from registered state only, with no combinational path from out_ready; a full buffer accepts no push even while a pop occurs.
REQ-017 out_valid SHALL be (count != 0); out_data SHALL be the entry at the read pointer (first-word fall-through).
REQ-018 Latency: a beat pushed in cycle N SHALL be visible at the output in cycle N+1 at the earliest; no same-cycle input-to-output bypass.
REQ-019 Beats SHALL leave in the order they entered, with no loss or duplication.
REQ-020 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-021 count update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-022 Write and read pointers SHALL each advance by 1 per push or pop and wrap from DEPTH-1 to 0.
REQ-023 Simultaneous push and pop at count=1 SHALL leave count=1, with the new beat at the head in the next cycle.
REQ-024 Flush takes priority over push and pop: the next cycle has count=0, both pointers at 0, out_valid=0 and in_ready=1; a push in the flush cycle is dropped.
REQ-025 Storage contents SHALL not be reset or cleared; only pointers and count carry state.
REQ-026 almost_full SHALL be a registered-state decode of count, updated in the same cycle as count.

Reset
REQ-027 While rst=1: count=0, both pointers=0, out_valid=0, in_ready=1, almost_full=0, and out_data is don't-care.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); normal operation resumes on the first clock edge after rst deasserts.

Structure
REQ-029 Shared package pipeline_pkg SHALL hold DEFAULT_DATA_WIDTH (32) and DEFAULT_DEPTH (4), plus a ptr_t typedef width helper used by pipeline blocks.
REQ-030 One sub-module, pipeline_buf_ptr (wrapping pointer counter with increment and clear), SHALL be instantiated twice: once as the write pointer, once as the read pointer.
REQ-031 Storage SHALL be a flop array of DEPTH x DATA_WIDTH; no RAM macro.

Verification (DATA_WIDTH=32, DEPTH=4, AF_THRESH=3)
REQ-032 Fill: push 0xA0..0xA3 with out_ready=0 -> count 1,2,3,4; almost_full=1 at count 3; in_ready=0 at count 4; out_data=0xA0 throughout.
REQ-033 Full push+pop: at count=4, in_valid=1 with 0xB0 and out_ready=1 -> 0xA0 popped, 0xB0 not accepted, count=3, in_ready=1 next cycle.
REQ-034 Streaming: in_valid=1 and out_ready=1 continuously for 20 beats (0x00..0x13) -> one beat per cycle after the first, count steady at 1, order preserved, pointers wrap 5 times.
REQ-035 Flush: at count=3 assert flush together with a push of 0xC0 -> next cycle count=0, out_valid=0; 0xC0 never appears at the output.
REQ-036 Backpressure: random out_ready at 30% duty with random in_valid for 1000 beats -> scoreboard matches exactly; out_data stable whenever stalled.
REQ-037 Reset mid-stream: assert rst at count=2 between clock edges -> out_valid=0 and count=0 immediately; after release, push 0xD0 -> out_data=0xD0 one cycle later.
